alu_uart_intf: RTL and testbench

ALU_UART_INTF -- requirements
Module: alu_uart_intf

---
 rtl/alu_uart_intf.sv | 102 ++++++++++
 tb/tb_alu_uart_intf.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_intf.sv
// Sequences UART bytes A, B, opcode into an external ALU and returns its result byte.
// Latency: the result push strobe comes two cycles after the opcode pop, when TX has room.
// Backpressure: waits in SEND while TX is full; stalls in the GET states while RX is empty.
module alu_uart_intf #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 50000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_empty,
  input  logic [DATA_W-1:0] i_rx_data,
  output logic              o_rd_uart,
  input  logic              i_tx_full,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_wr_uart,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [OP_W-1:0]   o_alu_op,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_timeout
);

  // Counter only has to reach TIMEOUT-1, where the frame is abandoned.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

  state_t           state, state_nxt;
  logic             rd_block;   // set in the cycle after a pop so pops never land back to back
  logic [CNT_W-1:0] to_cnt;
  logic             pop;
  logic             waiting;    // mid-frame and starved of bytes

  // Next-state and strobe decode; a pop is allowed in any GET state unless one just happened.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    waiting   = 1'b0;
    o_rd_uart = 1'b0;
    o_wr_uart = 1'b0;
    o_timeout = 1'b0;
    case (state)
      GET_A: begin
        pop = !i_rx_empty && !rd_block;
        if (pop) state_nxt = GET_B;
      end
      GET_B, GET_OP: begin
        pop     = !i_rx_empty && !rd_block;
        waiting = i_rx_empty;
        if (pop) begin
          state_nxt = (state == GET_B) ? GET_OP : EXEC;
        end else if (waiting && to_cnt == CNT_MAX) begin
          o_timeout = 1'b1;
          state_nxt = GET_A;
        end
      end
      EXEC: state_nxt = SEND;
      SEND: begin
        if (!i_tx_full) begin
          o_wr_uart = 1'b1;
          state_nxt = GET_A;
        end
      end
      default: state_nxt = GET_A;
    endcase
    o_rd_uart = pop;
  end

  // State, pop spacing and idle counter; rd_block resets high so nothing pops while in reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= GET_A;
      rd_block <= 1'b1;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      rd_block <= pop;
      if (pop || state_nxt == GET_A)
        to_cnt <= '0;
      else if (waiting && to_cnt != CNT_MAX)
        to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // Operand capture on each byte's own pop edge and result capture in EXEC; all hold otherwise.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
    end else begin
      if (pop && state == GET_A)  o_alu_a  <= i_rx_data;
      if (pop && state == GET_B)  o_alu_b  <= i_rx_data;
      if (pop && state == GET_OP) o_alu_op <= i_rx_data[OP_W-1:0];
      if (state == EXEC)          o_tx_data <= i_alu_result;
    end
  end

endmodule

// File: tb/tb_alu_uart_intf.sv
// Bench for alu_uart_intf: unit 0 (TIMEOUT=16) fed from a queue-backed RX FIFO model,
// unit 1 (TIMEOUT=1000) fed directly for the gapped-arrival case.
// Expected results are queued at stimulus time and consumed by a negedge monitor.
module tb_alu_uart_intf;

  typedef struct {
    bit         is_to;
    logic [7:0] dat;
    int         lat;
  } exp_t;

  logic       clk, rst_n;
  logic       rx_empty0, rd0, tx_full0, wr0, to0;
  logic [7:0] rx_data0, tx_data0, a0, b0, res0;
  logic [5:0] op0;
  logic       rx_empty1, rd1, tx_full1, wr1, to1;
  logic [7:0] rx_data1, tx_data1, a1, b1, res1;
  logic [5:0] op1;

  exp_t       exp0[$], exp1[$];
  logic [7:0] rxq[$];
  bit         gap0;
  int         n_cmp, n_bad, cyc;
  int         pops[2], last_pop[2];
  bit         prev_pop[2];

  alu_uart_intf #(.DATA_W(8), .OP_W(6), .TIMEOUT(16)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_empty(rx_empty0), .i_rx_data(rx_data0),
    .o_rd_uart(rd0), .i_tx_full(tx_full0), .o_tx_data(tx_data0), .o_wr_uart(wr0),
    .o_alu_a(a0), .o_alu_b(b0), .o_alu_op(op0), .i_alu_result(res0), .o_timeout(to0));

  alu_uart_intf #(.DATA_W(8), .OP_W(6), .TIMEOUT(1000)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_empty(rx_empty1), .i_rx_data(rx_data1),
    .o_rd_uart(rd1), .i_tx_full(tx_full1), .o_tx_data(tx_data1), .o_wr_uart(wr1),
    .o_alu_a(a1), .o_alu_b(b1), .o_alu_op(op1), .i_alu_result(res1), .o_timeout(to1));

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign res0 = alu(a0, b0, op0);
  assign res1 = alu(a1, b1, op1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor per unit: pop spacing, then scoreboard match for every write or timeout strobe.
  task automatic mon_unit(input int u, input logic rd, input logic wr, input logic to,
                          input logic [7:0] d);
    exp_t e;
    bit   empty_q;
    if (rd === 1'b1) begin
      chk($sformatf("u%0d_pop_adjacent", u), {31'd0, prev_pop[u]}, 32'd0);
      last_pop[u] = cyc;
      pops[u]++;
    end
    prev_pop[u] = (rd === 1'b1);
    if (wr === 1'b1 || to === 1'b1) begin
      empty_q = (u == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
      if (empty_q) begin
        n_cmp++;
        n_bad++;
        $display("FAIL u%0d_unexpected_strobe: wr=%0b to=%0b data=0x%0h, none expected (cycle %0d)",
                 u, wr, to, d, cyc);
      end else begin
        e = (u == 0) ? exp0.pop_front() : exp1.pop_front();
        chk($sformatf("u%0d_strobe_kind_is_timeout", u), {31'd0, to}, {31'd0, e.is_to});
        if (!e.is_to) chk($sformatf("u%0d_tx_data", u), {24'd0, d}, {24'd0, e.dat});
        if (e.lat >= 0) chk($sformatf("u%0d_latency_from_pop", u), cyc - last_pop[u], e.lat);
      end
    end
  endtask

  // Sample all outputs on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      mon_unit(0, rd0, wr0, to0, tx_data0);
      mon_unit(1, rd1, wr1, to1, tx_data1);
    end
  end

  // RX FIFO model for unit 0: pop on a sampled strobe, refresh head just after each edge.
  initial begin
    bit         p;
    logic [7:0] tmp;
    forever begin
      @(negedge clk);
      p = (rd0 === 1'b1);
      @(posedge clk);
      #2;
      if (p && rxq.size() > 0) tmp = rxq.pop_front();
      rx_empty0 = gap0 || rxq.size() == 0;
      rx_data0  = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pops(input int u, input int target, input int budget);
    int k = 0;
    while (pops[u] < target && k < budget) begin
      tick(1);
      k++;
    end
    if (pops[u] < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL u%0d_wait_pops: saw %0d pops, expected %0d within %0d cycles", u, pops[u], target, budget);
    end
  endtask

  task automatic wait_drain(input int u, input int budget);
    int k = 0;
    while (((u == 0) ? exp0.size() : exp1.size()) != 0 && k < budget) begin
      tick(1);
      k++;
    end
    if (((u == 0) ? exp0.size() : exp1.size()) != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL u%0d_wait_result: %0d expected strobes still outstanding after %0d cycles",
               u, (u == 0) ? exp0.size() : exp1.size(), budget);
    end
  endtask

  function automatic exp_t wr_exp(input logic [7:0] d, input int lat);
    exp_t e;
    e.is_to = 1'b0;
    e.dat   = d;
    e.lat   = lat;
    return e;
  endfunction

  task automatic push3(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    rxq.push_back(x);
    rxq.push_back(y);
    rxq.push_back(z);
  endtask

  // Unit 1: present one byte, wait for it to be taken, then go empty again.
  task automatic feed1(input logic [7:0] d);
    int base = pops[1];
    rx_data1  = d;
    rx_empty1 = 1'b0;
    wait_pops(1, base + 1, 20);
    rx_empty1 = 1'b1;
  endtask

  initial begin
    int   base;
    exp_t e;
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0; gap0 = 1'b0;
    rx_empty0 = 1'b1; rx_data0 = 8'h00; tx_full0 = 1'b0;
    rx_empty1 = 1'b1; rx_data1 = 8'h00; tx_full1 = 1'b0;

    // Reset state
    tick(2);
    @(negedge clk);
    chk("rst_rd", {31'd0, rd0}, 0);
    chk("rst_wr", {31'd0, wr0}, 0);
    chk("rst_timeout", {31'd0, to0}, 0);
    chk("rst_alu_a", {24'd0, a0}, 0);
    chk("rst_tx_data", {24'd0, tx_data0}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // ADD: 0x04 + 0x80
    exp0.push_back(wr_exp(8'h84, 2));
    push3(8'h04, 8'h80, 8'h20);
    wait_pops(0, 3, 40);
    chk("add_alu_op", {26'd0, op0}, 32'h20);
    wait_drain(0, 20);
    chk("add_hold_a", {24'd0, a0}, 32'h04);
    chk("add_hold_b", {24'd0, b0}, 32'h80);

    // SUB with TX full for 5 cycles
    tx_full0 = 1'b1;
    exp0.push_back(wr_exp(8'h0D, -1));
    push3(8'h10, 8'h03, 8'h22);
    wait_pops(0, 6, 40);
    tick(1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_wr_low", {31'd0, wr0}, 0);
      chk("stall_tx_data", {24'd0, tx_data0}, 32'h0D);
      tick(1);
    end
    tx_full0 = 1'b0;
    wait_drain(0, 20);

    // Timeout after A only, then an OR frame
    e.is_to = 1'b1; e.dat = 8'h00; e.lat = 16;
    exp0.push_back(e);
    rxq.push_back(8'h55);
    wait_pops(0, 7, 20);
    wait_drain(0, 40);
    chk("to_keep_a", {24'd0, a0}, 32'h55);
    chk("to_keep_b", {24'd0, b0}, 32'h03);
    exp0.push_back(wr_exp(8'h03, 2));
    push3(8'h01, 8'h02, 8'h25);
    wait_drain(0, 40);

    // Reset after B, with the FIFO non-empty during reset
    base = pops[0];
    rxq.push_back(8'h11);
    rxq.push_back(8'h22);
    wait_pops(0, base + 2, 20);
    rst_n = 1'b0;
    rxq.push_back(8'hF0);
    tick(1);
    @(negedge clk);
    chk("midrst_rd", {31'd0, rd0}, 0);
    chk("midrst_wr", {31'd0, wr0}, 0);
    chk("midrst_timeout", {31'd0, to0}, 0);
    chk("midrst_alu_a", {24'd0, a0}, 0);
    chk("midrst_alu_b", {24'd0, b0}, 0);
    chk("midrst_alu_op", {26'd0, op0}, 0);
    chk("midrst_tx_data", {24'd0, tx_data0}, 0);
    tick(2);
    rst_n = 1'b1;
    exp0.push_back(wr_exp(8'hFF, 2));
    rxq.push_back(8'h0F);
    rxq.push_back(8'h26);
    wait_drain(0, 40);

    // Back-to-back frames preloaded
    base = pops[0];
    exp0.push_back(wr_exp(8'h08, 2));
    exp0.push_back(wr_exp(8'h1E, 2));
    push3(8'h0C, 8'h0A, 8'h24);
    push3(8'h30, 8'h12, 8'h22);
    wait_drain(0, 60);
    chk("b2b_pop_count", pops[0] - base, 6);

    // Gapped arrival on unit 1 (TIMEOUT=1000), 100 idle cycles between bytes
    exp1.push_back(wr_exp(8'h02, 2));
    feed1(8'h07);
    tick(100);
    feed1(8'h05);
    tick(100);
    feed1(8'h22);
    wait_drain(1, 20);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
